pipe_stall_ctrl: RTL and testbench

// - Parametrised pipeline stall/bubble controller for the LC-3b in-order pipeline. Default stages: 0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
// - Turns per-stage stall and bubble requests into per-stage register load enables and incoming valid bits.
// - Owns two sequencers:
//   - Branch-shadow FSM: squashes fetch while a branch is in flight.
//   - Multi-cycle indirect (LDI/STI) hold counter for EX.
// - Sits between the hazard/cache units and every stage pipeline register.

---
 rtl/pipe_stall_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble controller: per-stage load enables, incoming valid bits,
// branch-shadow FSM and indirect-op hold counter. Define PIPE_STALL_PERF_EN for stall counters.
module pipe_stall_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 3,
    parameter int IND_STAGE  = 2,
    parameter int IND_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_STAGES-1:0]       stage_valid,
    input  logic [NUM_STAGES-1:0]       stall_req,
    input  logic [NUM_STAGES-1:0]       bubble_req,
    input  logic                        br_decode,
    input  logic                        br_resolve,
    input  logic                        ind_req,
    output logic [NUM_STAGES-1:0]       load,
    output logic [NUM_STAGES-1:0]       valid_out,
    output logic                        br_busy,
    output logic                        ind_busy,
    output logic [NUM_STAGES*CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        BR_IDLE,
        BR_WAIT
    } br_state_t;

    br_state_t             br_state;
    logic [3:0]            ind_cnt;
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] adv;
    logic                  down_hold;
    logic                  ind_start;
    logic                  ind_hold;
    logic                  br_shadow;
    logic                  br_res_q;
    logic                  squash_if;
    logic                  unused_msb;

    // Stages past the indirect stage never see ind_hold, so their hold is just the stall suffix.
    assign down_hold = |stall_req[NUM_STAGES-1:IND_STAGE+1];
    assign ind_start = ind_req & stage_valid[IND_STAGE] & (ind_cnt == 4'd0) & ~down_hold;
    assign ind_hold  = (ind_cnt != 4'd0) | ind_start;
    assign ind_busy  = (ind_cnt != 4'd0);

    always_comb begin
        hold = '0;
        hold[NUM_STAGES-1] = stall_req[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            hold[i] = stall_req[i] | ((i == IND_STAGE) & ind_hold) | hold[i+1];
        end
    end

    assign adv       = ~hold;
    assign load      = rst_n ? adv : '0;
    assign br_shadow = (br_state != BR_IDLE) | br_decode;
    assign br_res_q  = br_resolve & adv[BR_STAGE+1];
    assign squash_if = br_shadow & ~adv[BR_STAGE+1];

    always_comb begin
        valid_out = '0;
        if (rst_n) begin
            valid_out[0] = ~squash_if;
            for (int i = 1; i < NUM_STAGES; i++) begin
                valid_out[i] = stage_valid[i-1] & adv[i-1] & ~bubble_req[i-1]
                             & ~(br_shadow & (i <= 1));
            end
        end
    end

    // A resolve arriving with the decode of a new branch wins: that decode is wrong-path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_state <= BR_IDLE;
            br_busy  <= 1'b0;
        end else begin
            case (br_state)
                BR_IDLE: begin
                    if (br_decode & adv[2] & ~br_res_q) begin
                        br_state <= BR_WAIT;
                        br_busy  <= 1'b1;
                    end
                end
                BR_WAIT: begin
                    if (br_res_q) begin
                        br_state <= BR_IDLE;
                        br_busy  <= 1'b0;
                    end
                end
                default: begin
                    br_state <= BR_IDLE;
                    br_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ind_cnt <= 4'd0;
        end else if (ind_start) begin
            ind_cnt <= 4'(IND_CYCLES);
        end else if ((ind_cnt != 4'd0) && !down_hold) begin
            ind_cnt <= ind_cnt - 4'd1;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_perf
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (hold[g] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign stall_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign stall_cnt = '0;
`endif

    // The last stage's valid and bubble have no downstream register to feed.
    assign unused_msb = stage_valid[NUM_STAGES-1] ^ bubble_req[NUM_STAGES-1];

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: directed scenarios plus random traffic against a
// rule-level reference model; honours PIPE_STALL_PERF_EN for the stall counters.
module tb_pipe_stall_ctrl;

    localparam int N    = 5;
    localparam int BR   = 3;
    localparam int IND  = 2;
    localparam int INDC = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  stage_valid, stall_req, bubble_req;
    logic          br_decode, br_resolve, ind_req;
    logic [N-1:0]  load, valid_out;
    logic          br_busy, ind_busy;
    logic [N*CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    bit              m_branch;
    int              m_ind_left;
    int              m_cnt [N];
    logic [N-1:0]    e_load, e_valid;
    logic            e_br, e_ind;
    logic [N*CW-1:0] e_cnt;

    pipe_stall_ctrl #(
        .NUM_STAGES(N), .BR_STAGE(BR), .IND_STAGE(IND), .IND_CYCLES(INDC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stage_valid(stage_valid), .stall_req(stall_req),
        .bubble_req(bubble_req), .br_decode(br_decode), .br_resolve(br_resolve),
        .ind_req(ind_req), .load(load), .valid_out(valid_out), .br_busy(br_busy),
        .ind_busy(ind_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model works from the rules directly: a stage is held if any stage at or after it stalls,
    // or if it sits at/upstream of the indirect stage while the indirect op occupies it.
    task automatic modelStep();
        logic [N-1:0] held;
        logic down, start, ihold, shadow, res_ok;
        if (!rst_n) begin
            m_branch   = 1'b0;
            m_ind_left = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            e_load = '0; e_valid = '0; e_br = 1'b0; e_ind = 1'b0; e_cnt = '0;
        end else begin
            down = 1'b0;
            for (int j = IND + 1; j < N; j++) if (stall_req[j]) down = 1'b1;
            start = ind_req && stage_valid[IND] && (m_ind_left == 0) && !down;
            ihold = (m_ind_left > 0) || start;
            for (int i = 0; i < N; i++) begin
                held[i] = 1'b0;
                for (int j = i; j < N; j++) if (stall_req[j]) held[i] = 1'b1;
                if (i <= IND && ihold) held[i] = 1'b1;
            end
            e_load   = ~held;
            shadow   = m_branch || br_decode;
            res_ok   = br_resolve && e_load[BR+1];
            e_valid[0] = !(shadow && !e_load[BR+1]);
            for (int i = 1; i < N; i++)
                e_valid[i] = stage_valid[i-1] && e_load[i-1] && !bubble_req[i-1] && !(i == 1 && shadow);
            e_br  = m_branch;
            e_ind = (m_ind_left > 0);
            e_cnt = '0;
`ifdef PIPE_STALL_PERF_EN
            for (int i = 0; i < N; i++) e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
`endif
            if (m_branch) begin
                if (res_ok) m_branch = 1'b0;
            end else if (br_decode && e_load[2] && !res_ok) begin
                m_branch = 1'b1;
            end
            if (start) m_ind_left = INDC;
            else if (m_ind_left > 0 && !down) m_ind_left--;
            for (int i = 0; i < N; i++)
                if (held[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic [N-1:0] sv,
                                 input logic [N-1:0] st, input logic [N-1:0] bb,
                                 input logic bd, input logic brr, input logic ir);
        @(negedge clk);
        rst_n = r; stage_valid = sv; stall_req = st; bubble_req = bb;
        br_decode = bd; br_resolve = brr; ind_req = ir;
        #1;
        modelStep();
        checkOutput({tag, "/load"},      load,      e_load);
        checkOutput({tag, "/valid_out"}, valid_out, e_valid);
        checkOutput({tag, "/br_busy"},   br_busy,   e_br);
        checkOutput({tag, "/ind_busy"},  ind_busy,  e_ind);
        checkOutput({tag, "/stall_cnt"}, stall_cnt, e_cnt);
    endtask

    function automatic logic [N-1:0] sparse(input int pct);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; stage_valid = '0; stall_req = '0; bubble_req = '0;
        br_decode = 1'b0; br_resolve = 1'b0; ind_req = 1'b0;
        m_branch = 1'b0; m_ind_left = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;

        applyStimulus("reset", 1'b0, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_load_lit", load, 5'b00000);
        checkOutput("reset_valid_lit", valid_out, 5'b00000);
        applyStimulus("reset", 1'b0, 5'b01111, 5'b0, 5'b0, 1'b1, 1'b0, 1'b1);

        applyStimulus("empty", 1'b1, 5'b00000, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("empty_valid_lit", valid_out, 5'b00001);
        applyStimulus("flow", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flow_load_lit", load, 5'b11111);
        checkOutput("flow_valid_lit", valid_out, 5'b11111);

        for (int k = 0; k < 3; k++) begin
            applyStimulus("mem_stall", 1'b1, 5'b01111, 5'b01000, 5'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("mem_stall_load_lit", load, 5'b10000);
            checkOutput("mem_stall_wb_valid_lit", valid_out[4], 1'b0);
        end
        applyStimulus("mem_release", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mem_release_wb_valid_lit", valid_out[4], 1'b1);

        applyStimulus("bubble", 1'b1, 5'b01111, 5'b0, 5'b00010, 1'b0, 1'b0, 1'b0);
        checkOutput("bubble_valid_lit", valid_out, 5'b11011);
        checkOutput("bubble_load_lit", load, 5'b11111);
        applyStimulus("after_bubble", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_bubble_valid_lit", valid_out, 5'b11111);

        applyStimulus("br_t0", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("br_t0_id_valid_lit", valid_out[1], 1'b0);
        checkOutput("br_t0_busy_lit", br_busy, 1'b0);
        applyStimulus("br_t1", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("br_t1_busy_lit", br_busy, 1'b1);
        applyStimulus("br_t2", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("br_t2_id_valid_lit", valid_out[1], 1'b0);
        checkOutput("br_t2_busy_lit", br_busy, 1'b1);
        applyStimulus("br_t3", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("br_t3_busy_lit", br_busy, 1'b0);
        checkOutput("br_t3_id_valid_lit", valid_out[1], 1'b1);

        applyStimulus("ind_t0", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ind_t0_load_lit", load, 5'b11000);
        checkOutput("ind_t0_mem_valid_lit", valid_out[3], 1'b0);
        applyStimulus("ind_t1", 1'b1, 5'b01111, 5'b01000, 5'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ind_t1_load_lit", load, 5'b10000);
        applyStimulus("ind_t2", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ind_t2_load_lit", load, 5'b11000);
        checkOutput("ind_t2_mem_valid_lit", valid_out[3], 1'b0);
        applyStimulus("ind_t3", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ind_t3_load_lit", load, 5'b11000);
        checkOutput("ind_t3_busy_lit", ind_busy, 1'b1);
        applyStimulus("ind_t4", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ind_t4_load_lit", load, 5'b11111);
        checkOutput("ind_t4_busy_lit", ind_busy, 1'b0);

        applyStimulus("rst_mid_t0", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("rst_mid_t1", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("rst_mid_t2", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_mid_t2_br_busy_lit", br_busy, 1'b1);
        applyStimulus("rst_mid_t3", 1'b0, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_mid_load_lit", load, 5'b00000);
        checkOutput("rst_mid_ind_busy_lit", ind_busy, 1'b0);
        applyStimulus("rst_mid_t4", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_mid_after_br_lit", br_busy, 1'b0);
        checkOutput("rst_mid_after_ind_lit", ind_busy, 1'b0);

        for (int k = 0; k < 20; k++)
            applyStimulus("if_stall", 1'b1, 5'b01111, 5'b00001, 5'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("if_release", 1'b1, 5'b01111, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STALL_PERF_EN
        checkOutput("perf_saturate_lit", stall_cnt[CW-1:0], 4'hF);
`else
        checkOutput("perf_absent_lit", stall_cnt, '0);
`endif

        for (int k = 0; k < 400; k++) begin
            applyStimulus("random", ($urandom_range(0, 39) != 0), N'($urandom), sparse(12),
                          sparse(15), ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25));
        end

        $display("[TB] random phase complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
